// File: rtl/router_pkt_src_if.sv
// router_pkt_src_if: bundles the buffer write port, the start command and
// the router-facing byte stream of the packet source.
//   master : the packet source (drives status, pkt_valid/data_out, pulses)
//   slave  : whoever stages payload, issues start and models the router
interface router_pkt_src_if;
  logic       wr_en;        // payload buffer write strobe
  logic [7:0] wr_data;      // payload byte to write
  logic [5:0] buf_count;    // bytes currently staged
  logic       buf_full;     // buf_count == MAX_LEN
  logic       start;        // single-cycle transmit request
  logic [1:0] dest_addr;    // destination port, sampled with start
  logic       inj_err;      // sampled with start, 1 = inverted parity
  logic       router_busy;  // router stall
  logic       pkt_valid;    // high during header and payload bytes
  logic [7:0] data_out;     // byte to router
  logic       tx_active;    // high from HEADER through GAP
  logic       done;         // pulse when parity byte is consumed
  logic       start_err;    // pulse when start is rejected
  logic [7:0] pkt_count;    // packets sent, wrapping

  modport master (
    input  wr_en, wr_data, start, dest_addr, inj_err, router_busy,
    output buf_count, buf_full, pkt_valid, data_out, tx_active, done,
           start_err, pkt_count
  );

  modport slave (
    output wr_en, wr_data, start, dest_addr, inj_err, router_busy,
    input  buf_count, buf_full, pkt_valid, data_out, tx_active, done,
           start_err, pkt_count
  );
endinterface

// File: rtl/router_pkt_src.sv
// router_pkt_src: packet source for the 1x3 router. Payload bytes are staged
// into an internal buffer while idle; a start command sends the buffer as
// header {len,dest}, payload bytes and a parity byte (XOR of header and
// payload, optionally inverted), honouring router_busy back-pressure.
// Ports:
//   clock  : rising-edge clock
//   resetn : synchronous, active-low reset
//   bus    : router_pkt_src_if.master (write port, start command, byte
//            stream to the router, status and pulse outputs)
module router_pkt_src #(
  parameter int MAX_LEN    = 63,  // buffer depth, 1..63 (6-bit length field)
  parameter int GAP_CYCLES = 2    // idle cycles after parity, >= 1
) (
  input  logic              clock,
  input  logic              resetn,
  router_pkt_src_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // Final parity byte: running XOR folded with the last payload byte,
  // inverted when an error is being injected.
  function automatic logic [7:0] parity_out(input logic [7:0] acc,
                                            input logic [7:0] last,
                                            input logic       inv);
    return (acc ^ last) ^ {8{inv}};
  endfunction

  state_t           state_r;
  logic [7:0]       mem [MAX_LEN];
  logic [5:0]       buf_count_r;
  logic             buf_full_r;
  logic [5:0]       idx_r;
  logic [5:0]       len_r;
  logic [7:0]       parity_r;
  logic             err_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             pkt_valid_r;
  logic [7:0]       data_out_r;
  logic             tx_active_r;
  logic             done_r;
  logic             start_err_r;
  logic [7:0]       pkt_count_r;

  logic             wr_ok_s;
  logic [5:0]       eff_count_s;
  logic             start_ok_s;

  // A same-cycle write lands before start is evaluated, so the packet
  // length is the count including that write.
  assign wr_ok_s     = (state_r == S_IDLE) && bus.wr_en && !buf_full_r;
  assign eff_count_s = buf_count_r + {5'd0, wr_ok_s};
  assign start_ok_s  = (bus.dest_addr != 2'd3) && (eff_count_s != 6'd0);

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clock) begin
    if (wr_ok_s) begin
      mem[buf_count_r] <= bus.wr_data;
    end
  end

  // Packet FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      buf_count_r <= 6'd0;
      buf_full_r  <= 1'b0;
      idx_r       <= 6'd0;
      len_r       <= 6'd0;
      parity_r    <= 8'd0;
      err_r       <= 1'b0;
      gap_cnt_r   <= '0;
      pkt_valid_r <= 1'b0;
      data_out_r  <= 8'd0;
      tx_active_r <= 1'b0;
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
      pkt_count_r <= 8'd0;
    end else begin
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (wr_ok_s) begin
            buf_count_r <= eff_count_s;
            buf_full_r  <= (eff_count_s == MAX_LEN_C);
          end
          if (bus.start) begin
            if (start_ok_s) begin
              state_r     <= S_HEADER;
              pkt_valid_r <= 1'b1;
              data_out_r  <= {eff_count_s, bus.dest_addr};
              len_r       <= eff_count_s;
              err_r       <= bus.inj_err;
              tx_active_r <= 1'b1;
            end else begin
              start_err_r <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!bus.router_busy) begin
            parity_r   <= data_out_r;
            idx_r      <= 6'd0;
            data_out_r <= mem[6'd0];
            state_r    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.router_busy) begin
            parity_r <= parity_r ^ data_out_r;
            if (idx_r == len_r - 6'd1) begin
              data_out_r  <= parity_out(parity_r, data_out_r, err_r);
              pkt_valid_r <= 1'b0;
              state_r     <= S_PARITY;
            end else begin
              idx_r      <= idx_r + 6'd1;
              data_out_r <= mem[idx_r + 6'd1];
            end
          end
        end
        S_PARITY: begin
          if (!bus.router_busy) begin
            done_r      <= 1'b1;
            pkt_count_r <= pkt_count_r + 8'd1;
            buf_count_r <= 6'd0;
            buf_full_r  <= 1'b0;
            pkt_valid_r <= 1'b0;
            data_out_r  <= 8'd0;
            gap_cnt_r   <= '0;
            state_r     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r     <= S_IDLE;
            tx_active_r <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          pkt_valid_r <= 1'b0;
          tx_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buf_count = buf_count_r;
  assign bus.buf_full  = buf_full_r;
  assign bus.pkt_valid = pkt_valid_r;
  assign bus.data_out  = data_out_r;
  assign bus.tx_active = tx_active_r;
  assign bus.done      = done_r;
  assign bus.start_err = start_err_r;
  assign bus.pkt_count = pkt_count_r;

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: self-checking bench for router_pkt_src. A queue-based
// model holds the staged payload; each packet's expected byte stream is built
// from it (header, payload, XOR parity) and compared byte by byte while
// router_busy and noise on wr_en/start are randomized.
module tb_router_pkt_src;
  localparam int MAX_LEN = 63;
  localparam int GAP     = 2;

  logic clock = 1'b0;
  logic resetn;

  router_pkt_src_if bus();

  router_pkt_src #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] model_buf[$];
  int model_pkts = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en       = 1'b0;
    bus.wr_data     = 8'd0;
    bus.start       = 1'b0;
    bus.dest_addr   = 2'd0;
    bus.inj_err     = 1'b0;
    bus.router_busy = 1'b0;
  endtask

  task automatic stage_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (model_buf.size() < MAX_LEN) model_buf.push_back(b);
    @(negedge clock);
    bus.wr_en = 1'b0;
  endtask

  // Sends the staged packet and checks every byte, the done pulse, the
  // counters and the gap length. hold_k/hold_n force busy for hold_n
  // cycles while byte hold_k is presented.
  task automatic send_packet(input logic [1:0] dest, input logic err,
                             input logic wr_with_start, input logic [7:0] wb,
                             input int hold_k, input int hold_n, input int busy_pct);
    logic [7:0] want_q[$];
    logic [7:0] acc;
    int len, k, held, cycles, gap_n;
    logic busy;
    if (wr_with_start) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = wb;
      if (model_buf.size() < MAX_LEN) model_buf.push_back(wb);
    end
    len = model_buf.size();
    acc = {len[5:0], dest};
    want_q.push_back(acc);
    foreach (model_buf[i]) begin
      want_q.push_back(model_buf[i]);
      acc = acc ^ model_buf[i];
    end
    want_q.push_back(err ? ~acc : acc);
    bus.start       = 1'b1;
    bus.dest_addr   = dest;
    bus.inj_err     = err;
    bus.router_busy = 1'b0;
    @(negedge clock);
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.inj_err = 1'b0;
    k = 0; held = 0; cycles = 0;
    while (k < len + 2 && cycles < 5000) begin
      check_eq("data_out", 32'(bus.data_out), 32'(want_q[k]));
      check_eq("pkt_valid", 32'(bus.pkt_valid), 32'(k <= len));
      check_eq("tx_active", 32'(bus.tx_active), 32'd1);
      check_eq("done_early", 32'(bus.done), 32'd0);
      check_eq("start_err_tx", 32'(bus.start_err), 32'd0);
      if (k == hold_k && held < hold_n) begin
        busy = 1'b1;
        held++;
      end else begin
        busy = ($urandom_range(99) < busy_pct);
      end
      bus.router_busy = busy;
      bus.wr_en       = 1'($urandom_range(1));
      bus.wr_data     = 8'($urandom);
      bus.start       = 1'($urandom_range(1));
      bus.dest_addr   = 2'($urandom_range(3));
      @(negedge clock);
      if (!busy) k++;
      cycles++;
    end
    check_eq("tx_timeout", 32'(k), 32'(len + 2));
    model_buf.delete();
    model_pkts = (model_pkts + 1) % 256;
    check_eq("done", 32'(bus.done), 32'd1);
    check_eq("pkt_count", 32'(bus.pkt_count), 32'(model_pkts));
    check_eq("buf_count_after", 32'(bus.buf_count), 32'd0);
    check_eq("buf_full_after", 32'(bus.buf_full), 32'd0);
    check_eq("pkt_valid_after", 32'(bus.pkt_valid), 32'd0);
    check_eq("data_out_after", 32'(bus.data_out), 32'd0);
    check_eq("tx_active_gap", 32'(bus.tx_active), 32'd1);
    gap_n = 0;
    while (bus.tx_active && gap_n < 50) begin
      bus.router_busy = 1'($urandom_range(1));
      bus.wr_en       = 1'($urandom_range(1));
      bus.wr_data     = 8'($urandom);
      bus.start       = 1'($urandom_range(1));
      bus.dest_addr   = 2'($urandom_range(3));
      @(negedge clock);
      gap_n++;
      check_eq("done_single", 32'(bus.done), 32'd0);
    end
    idle_inputs();
    check_eq("gap_len", 32'(gap_n), 32'(GAP));
    check_eq("buf_count_idle", 32'(bus.buf_count), 32'd0);
    check_eq("start_err_gap", 32'(bus.start_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, ws;
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
    check_eq("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    check_eq("rst_buf_count", 32'(bus.buf_count), 32'd0);
    check_eq("rst_buf_full", 32'(bus.buf_full), 32'd0);
    check_eq("rst_tx_active", 32'(bus.tx_active), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_start_err", 32'(bus.start_err), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Basic packet, no stall.
    stage_byte(8'h11); stage_byte(8'h22); stage_byte(8'h33);
    check_eq("staged_count", 32'(bus.buf_count), 32'd3);
    send_packet(2'd1, 1'b0, 1'b0, 8'h00, -1, 0, 0);

    // Stall for 3 cycles while 0x22 is presented.
    stage_byte(8'h11); stage_byte(8'h22); stage_byte(8'h33);
    send_packet(2'd1, 1'b0, 1'b0, 8'h00, 2, 3, 0);

    // Injected parity error.
    stage_byte(8'h11); stage_byte(8'h22); stage_byte(8'h33);
    send_packet(2'd1, 1'b1, 1'b0, 8'h00, -1, 0, 0);

    // Rejected starts: bad destination keeps the staged data.
    stage_byte(8'h11); stage_byte(8'h22); stage_byte(8'h33);
    bus.start = 1'b1; bus.dest_addr = 2'd3;
    @(negedge clock);
    bus.start = 1'b0; bus.dest_addr = 2'd0;
    check_eq("bad_dest_err", 32'(bus.start_err), 32'd1);
    check_eq("bad_dest_pv", 32'(bus.pkt_valid), 32'd0);
    check_eq("bad_dest_tx", 32'(bus.tx_active), 32'd0);
    check_eq("bad_dest_keep", 32'(bus.buf_count), 32'd3);
    @(negedge clock);
    check_eq("bad_dest_pulse", 32'(bus.start_err), 32'd0);
    send_packet(2'd0, 1'b0, 1'b0, 8'h00, -1, 0, 25);
    bus.start = 1'b1; bus.dest_addr = 2'd1;
    @(negedge clock);
    bus.start = 1'b0;
    check_eq("empty_err", 32'(bus.start_err), 32'd1);
    check_eq("empty_pv", 32'(bus.pkt_valid), 32'd0);
    check_eq("empty_tx", 32'(bus.tx_active), 32'd0);
    @(negedge clock);
    check_eq("empty_pulse", 32'(bus.start_err), 32'd0);

    // Overfill: 64 writes saturate at MAX_LEN.
    for (int i = 0; i < 64; i++) stage_byte(8'h01);
    check_eq("full_count", 32'(bus.buf_count), 32'(MAX_LEN));
    check_eq("full_flag", 32'(bus.buf_full), 32'd1);
    send_packet(2'd2, 1'b0, 1'b0, 8'h00, -1, 0, 20);

    // Reset in the middle of the 2nd payload byte.
    stage_byte(8'h11); stage_byte(8'h22); stage_byte(8'h33);
    bus.start = 1'b1; bus.dest_addr = 2'd1;
    @(negedge clock);
    bus.start = 1'b0;
    check_eq("mid_hdr", 32'(bus.data_out), 32'h0D);
    @(negedge clock);
    check_eq("mid_b0", 32'(bus.data_out), 32'h11);
    @(negedge clock);
    check_eq("mid_b1", 32'(bus.data_out), 32'h22);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    model_buf.delete();
    model_pkts = 0;
    check_eq("mid_rst_pv", 32'(bus.pkt_valid), 32'd0);
    check_eq("mid_rst_data", 32'(bus.data_out), 32'd0);
    check_eq("mid_rst_cnt", 32'(bus.pkt_count), 32'd0);
    check_eq("mid_rst_buf", 32'(bus.buf_count), 32'd0);
    check_eq("mid_rst_tx", 32'(bus.tx_active), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_rst_done", 32'(bus.done), 32'd0);
      @(negedge clock);
    end
    stage_byte(8'h11); stage_byte(8'h22); stage_byte(8'h33);
    send_packet(2'd1, 1'b0, 1'b0, 8'h00, -1, 0, 0);

    // Randomized packets, some with the last byte written alongside start.
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(20, 1);
      ws  = $urandom_range(1);
      for (int i = 0; i < len - ws; i++) stage_byte(8'($urandom));
      send_packet(2'($urandom_range(2)), 1'($urandom_range(1)), 1'(ws),
                  8'($urandom), -1, 0, 30);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
